// File: rtl/demux_sel_sequencer.sv
// Round-robin sequencer that drives demux_1_to_8 sel/data_in with dwell pulses and break-before-make gaps.
// Define DEMUX_SEQ_FIXED_PRIO_EN to use fixed priority (lowest request index wins) instead of round-robin.
module demux_sel_sequencer #(
  parameter int NUM_CH  = 8,
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_CH-1:0]  req,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   sel,
  output logic               data_out,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] GAP    = 2'd2;

  logic [1:0]         state;
  logic [SEL_W-1:0]   ptr;
  logic [DWELL_W-1:0] cnt;
  logic [SEL_W-1:0]   winner;
  logic               found;
  logic [SEL_W-1:0]   idx;

`ifdef DEMUX_SEQ_FIXED_PRIO_EN
  // Scanning downward lets the lowest set index overwrite any higher one.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = SEL_W'(i);
      if (req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end
`else
  // Search starts at ptr; the SEL_W-bit add wraps because NUM_CH is a power of two.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    idx    = ptr;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = ptr + SEL_W'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= '0;
      data_out <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ptr      <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (en && found) begin
            state    <= ACTIVE;
            sel      <= winner;
            data_out <= 1'b1;
            busy     <= 1'b1;
            cnt      <= (dwell == '0) ? DWELL_W'(1) : dwell;
          end else begin
            data_out <= 1'b0;
            busy     <= 1'b0;
          end
        end
        ACTIVE: begin
          // sel stays put here; data_out drops first so the demux never strobes a wrong output.
          cnt <= cnt - DWELL_W'(1);
          if (!en || cnt == DWELL_W'(1)) begin
            state    <= GAP;
            data_out <= 1'b0;
            done     <= 1'b1;
`ifndef DEMUX_SEQ_FIXED_PRIO_EN
            ptr      <= sel + SEL_W'(1);
`endif
          end
        end
        GAP: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          data_out <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule
